// File: rtl/reg6_arbiter_pkg.sv
// reg6_arbiter_pkg: shared opcodes, FSM states and register width for the reg6 arbiter
package reg6_arbiter_pkg;
  localparam int REG_W = 6;
  localparam logic [REG_W-1:0] REG_MAX = 6'd63;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/reg6_arbiter_if.sv
// reg6_arbiter_if: requester handshake plus reg6 control/readback bundle
// ports: req/op/din in from requesters, gnt/ack/err/busy back; reg_set/reg_D/reg_inc/reg_dec to reg6, reg_Q from reg6
interface reg6_arbiter_if import reg6_arbiter_pkg::*; #(parameter int NREQ = 3);
  logic [NREQ-1:0] req;
  logic [2*NREQ-1:0] op;
  logic [REG_W*NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic ack;
  logic err;
  logic busy;
  logic reg_set;
  logic [REG_W-1:0] reg_D;
  logic reg_inc;
  logic reg_dec;
  logic [REG_W-1:0] reg_Q;
  modport slave (input req, op, din, reg_Q, output gnt, ack, err, busy, reg_set, reg_D, reg_inc, reg_dec);
  modport master (output req, op, din, input gnt, ack, err, busy);
  modport regport (input reg_set, reg_D, reg_inc, reg_dec, output reg_Q);
endinterface

// File: rtl/reg6.sv
// reg6: 6-bit register with load and edge-triggered inc/dec (one step per strobe pulse)
// ports: i_set/i_d load, i_inc/i_dec step, o_q value
module reg6 import reg6_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic [REG_W-1:0] i_d,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [REG_W-1:0] o_q
);
  logic [REG_W-1:0] r_q;
  logic r_inc_d, r_dec_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      r_inc_d <= 1'b0;
      r_dec_d <= 1'b0;
    end else begin
      r_inc_d <= i_inc;
      r_dec_d <= i_dec;
      if (i_set) r_q <= i_d;
      else if (i_inc && !r_inc_d) r_q <= r_q + 1'b1;
      else if (i_dec && !r_dec_d) r_q <= r_q - 1'b1;
    end
  assign o_q = r_q;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or above i_ptr
// ports: i_req requests, i_ptr start index; o_onehot/o_idx winner, o_any any request
module rr_pick #(
  parameter int NREQ = 3,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  // scan from the farthest slot back to i_ptr so the closest set request wins
  always_comb begin
    o_onehot = '0;
    o_idx = '0;
    o_any = |i_req;
    for (int k = NREQ - 1; k >= 0; k--)
      o_idx = i_req[(int'(i_ptr) + k) % NREQ] ? IW'((int'(i_ptr) + k) % NREQ) : o_idx;
    o_onehot[o_idx] = o_any;
  end
endmodule

// File: rtl/reg6_arbiter.sv
// reg6_arbiter: round-robin sharing of one reg6 among NREQ requesters with held strobes and ack/err
// ports: clk, rst_n (async, active-low); bus.slave carries req/op/din/gnt/ack/err/busy and the reg6 strobes/readback
module reg6_arbiter import reg6_arbiter_pkg::*; #(
  parameter int NREQ = 3,
  parameter int HOLD = 1,
  parameter int WRAP = 0
) (
  input logic           clk,
  input logic           rst_n,
  reg6_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_e r_state, w_next;
  logic [IW-1:0] r_idx, r_ptr, w_idx;
  logic [NREQ-1:0] r_gnt, w_onehot;
  logic w_any, w_exec;
  op_e r_op;
  logic [REG_W-1:0] r_din;
  logic r_refuse;
  logic [1:0] r_cnt;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req(bus.req),
    .i_ptr(r_ptr),
    .o_onehot(w_onehot),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_gnt <= '0;
      r_op <= OP_NOP;
      r_din <= '0;
      r_refuse <= 1'b0;
      r_cnt <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_idx <= w_idx;
        r_gnt <= w_onehot;
        r_op <= op_e'(bus.op[2*int'(w_idx) +: 2]);
        r_din <= bus.din[REG_W*int'(w_idx) +: REG_W];
      end
      // refusal is decided once from the readback seen during GRANT
      if (r_state == S_GRANT) begin
        r_refuse <= (WRAP == 0) && ((r_op == OP_INC && bus.reg_Q == REG_MAX) || (r_op == OP_DEC && bus.reg_Q == '0));
        r_cnt <= 2'(HOLD - 1);
      end
      if (r_state == S_EXEC) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_DONE) r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
    end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_any ? S_GRANT : S_IDLE) :
             (r_state == S_GRANT) ? S_EXEC :
             (r_state == S_EXEC) ? ((r_cnt == '0) ? S_DONE : S_EXEC) : S_IDLE;
    w_exec = r_state == S_EXEC && !r_refuse;
    bus.gnt = (r_state != S_IDLE) ? r_gnt : '0;
    bus.busy = r_state != S_IDLE;
    bus.ack = r_state == S_DONE;
    bus.err = r_state == S_DONE && r_refuse;
    bus.reg_set = w_exec && r_op == OP_LOAD;
    bus.reg_inc = w_exec && r_op == OP_INC;
    bus.reg_dec = w_exec && r_op == OP_DEC;
    bus.reg_D = r_din;
  end
endmodule

// File: doc/reg6_arbiter.md
Name: reg6_arbiter

Overview:
- Shares one 6-bit register (reg6: set/D/Q/inc/dec) among NREQ requesters, e.g. fetch, stack and debug units.
- Round-robin arbitration; one committed command per grant.
- Sequences the register control strobes with a fixed hold time, then returns an ack/err handshake to the winner.
- Guards against unintended wrap-around on inc/dec.

Parameters:
- NREQ, 3, number of requesters (2..4).
- HOLD, 1, cycles each register control strobe stays asserted (1..3).
- WRAP, 0, 1 = allow inc at 63 / dec at 0 to wrap; 0 = refuse and flag err.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high until ack.
- op  in  2*NREQ  per-requester opcode, requester i at bits [2i+1:2i]; 00 NOP, 01 LOAD, 10 INC, 11 DEC.
- din  in  6*NREQ  per-requester load data, requester i at bits [6i+5:6i].
- gnt  out  NREQ  one-hot grant, high from GRANT through DONE.
- ack  out  1  one-cycle completion pulse, valid for the granted requester.
- err  out  1  qualifies ack; 1 = command refused.
- busy  out  1  high whenever state != IDLE.
- reg_set  out  1  drives reg6 set.
- reg_D  out  6  drives reg6 D.
- reg_inc  out  1  drives reg6 inc.
- reg_dec  out  1  drives reg6 dec.
- reg_Q  in  6  reg6 Q readback.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=0; gnt=0, ack=0, err=0, busy=0, reg_set=reg_inc=reg_dec=0, reg_D=0. Takes effect immediately, including mid-EXEC: strobes drop with no completion pulse.
- FSM states: IDLE, GRANT, EXEC, DONE.
- IDLE:
  - If any req is high, the winner is the first set req scanning from the rr pointer upward (mod NREQ).
  - Latch the winner index, its op and its din.
  - Go to GRANT.
- GRANT (1 cycle):
  - gnt[winner]=1.
  - Sample reg_Q into q_lat.
  - Compute refuse = (!WRAP && op==INC && q_lat==63) || (!WRAP && op==DEC && q_lat==0).
  - Go to EXEC.
- EXEC (HOLD cycles, down-counter):
  - LOAD: reg_set=1, reg_D=latched din.
  - INC: reg_inc=1.
  - DEC: reg_dec=1.
  - NOP or refuse: no strobe asserted.
  - At most one strobe is high at any time. reg_D holds the latched din through EXEC and DONE.
  - Go to DONE when the counter expires.
- DONE (1 cycle):
  - All strobes 0.
  - ack=1; err=refuse.
  - gnt is still high.
  - rr pointer = (winner+1) mod NREQ.
  - Go to IDLE.
- Latency: req first sampled in IDLE at cycle n → gnt at n+1 → strobes at n+2..n+1+HOLD → ack at n+2+HOLD → IDLE at n+3+HOLD. The earliest next grant is at n+4+HOLD.
- Commitment: once latched, the command completes even if req drops. The ack still pulses; the requester ignores it.
- Inputs op and din are not re-sampled after IDLE; changes during a grant have no effect.
- Simultaneous requests: resolved by the rr pointer only. Each requester with req held continuously is served within NREQ grants.
- WRAP=1: inc at 63 yields 0 and dec at 0 yields 63, as performed by reg6; err is always 0.
- Out-of-range width: none. All arithmetic lives in reg6; the controller only compares q_lat to 0 and 63.

Decomposition:
- Shared package/include: opcode constants OP_NOP/OP_LOAD/OP_INC/OP_DEC (2-bit), FSM state encodings, REG_W=6, REG_MAX=63.
- One sub-module: rr_pick. It is combinational: inputs req, ptr; outputs one-hot winner and index.
- The FSM, hold counter and strobe decode stay in reg6_arbiter.
- The bench instantiates reg6_arbiter together with a real reg6 instance.

Test Plan:
- Single LOAD: reset, reg6 Q=0; req[0]=1, op0=01, din0=27, HOLD=1 → gnt=001 at n+1; reg_set=1 and reg_D=27 at n+2; ack=1, err=0 at n+3; Q=27.
- Round-robin: req=111, ops all INC, Q=10 → grants in order 001, 010, 100, 001; Q reads 11, 12, 13, 14 after successive acks; busy never drops between back-to-back grants except for one IDLE cycle.
- Saturation, WRAP=0: LOAD 63, then INC → no reg_inc pulse, ack with err=1, Q stays 63. LOAD 0, then DEC → err=1, Q stays 0.
- Wrap, WRAP=1: LOAD 63, then INC → err=0, Q=0. DEC → Q=63.
- HOLD=3 and NOP: INC → reg_inc high for exactly 3 cycles, ack at n+5. NOP → ack at n+5 with no strobes.
- Reset mid-EXEC, HOLD=3: assert rst_n=0 during the second EXEC cycle → reg_inc, gnt and busy drop asynchronously; no ack is ever produced. After release, req[1] pending wins first because the rr pointer is back at 0 and req[0]=0.
